// File: rtl/ahb_lite_reg_slave.sv
// ahb_lite_reg_slave
// AHB-Lite register-bank responder. Holds 2**REGS_EXP 32-bit registers. The
// highest-indexed register is a read-only ID word. Byte, halfword and word
// accesses are supported. Bad accesses get a two-cycle ERROR response. All
// register contents are exported flat for fabric logic.
//
// Optional feature macro: AHB_REG_SLAVE_WAIT_EN
//   defined   : WAIT state and counter are built; WAIT_CYCLES (0..15) wait
//               states are inserted per non-error data phase
//   undefined : every non-error access is zero-wait
//
// Ports
//   HCLK, HRESETn    bus clock, asynchronous active-low reset
//   HSEL             slave select from the address decoder
//   HADDR, HTRANS    address-phase address and transfer type
//   HWRITE, HSIZE    address-phase direction and size
//   HWDATA           data-phase write data
//   HREADY           bus-level ready from the response mux
//   HREADYOUT        this slave's ready
//   HRESP            0 = OKAY, 1 = ERROR
//   HRDATA           data-phase read data (full word, lanes not shifted)
//   REGS_FLAT        register i on bits [32*i+31:32*i]
module ahb_lite_reg_slave #(
    parameter int          REGS_EXP    = 3,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h5052_4953
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         HSEL,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [31:0]                  HWDATA,
    input  logic                         HREADY,
    output logic                         HREADYOUT,
    output logic                         HRESP,
    output logic [31:0]                  HRDATA,
    output logic [(2**REGS_EXP)*32-1:0]  REGS_FLAT
);

    localparam int                  NREGS  = 2**REGS_EXP;
    localparam logic [REGS_EXP-1:0] ID_IDX = REGS_EXP'(NREGS - 1);

`ifdef AHB_REG_SLAVE_WAIT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
    logic [3:0] cnt_reg, cnt_next;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;
    localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

    state_t state_reg, state_next;

    // Address bits above the word index are not decoded here.
    logic unused_haddr;
    assign unused_haddr = ^HADDR[31:REGS_EXP+2];

    // Address-phase decode.
    logic                cap;
    logic [REGS_EXP-1:0] idx_now;
    logic                err_now;

    assign cap     = HSEL && HREADY && HTRANS[1];
    assign idx_now = HADDR[REGS_EXP+1:2];
    assign err_now = (HSIZE > 3'b010)
                  || (HSIZE == 3'b001 && HADDR[0])
                  || (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
                  || (HWRITE && idx_now == ID_IDX);

    // Captured address-phase state. Held while the bus is stalled.
    logic                valid_reg;
    logic                err_reg;
    logic                write_reg;
    logic [REGS_EXP-1:0] idx_reg;
    logic [1:0]          lo_reg;
    logic [2:0]          size_reg;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            write_reg <= 1'b0;
            idx_reg   <= '0;
            lo_reg    <= '0;
            size_reg  <= '0;
        end else if (HREADY) begin
            valid_reg <= cap;
            if (cap) begin
                err_reg   <= err_now;
                write_reg <= HWRITE;
                idx_reg   <= idx_now;
                lo_reg    <= HADDR[1:0];
                size_reg  <= HSIZE;
            end
        end
    end

    // Response FSM.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg <= ST_IDLE;
`ifdef AHB_REG_SLAVE_WAIT_EN
            cnt_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
`ifdef AHB_REG_SLAVE_WAIT_EN
            cnt_reg   <= cnt_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
`ifdef AHB_REG_SLAVE_WAIT_EN
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            ST_IDLE, ST_ERR2: begin
                if (state_reg == ST_ERR2) begin
                    HRESP      = 1'b1;
                    state_next = ST_IDLE;
                end
                // The state entered here governs the data phase of the
                // transfer being captured on this edge.
                if (cap) begin
                    if (err_now) begin
                        state_next = ST_ERR1;
                    end
`ifdef AHB_REG_SLAVE_WAIT_EN
                    else if (WAIT_CYCLES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
`endif
                end
            end
`ifdef AHB_REG_SLAVE_WAIT_EN
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_reg == 4'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
`endif
            ST_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                state_next = ST_ERR2;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Write commit on the completing data-phase edge only.
    logic       commit;
    logic [3:0] be;

    assign commit = valid_reg && write_reg && !err_reg && (state_reg == ST_IDLE);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            always_comb begin
                case (size_reg)
                    3'b000:  be[gi] = (lo_reg == 2'(gi));
                    3'b001:  be[gi] = (lo_reg[1] == 1'(gi >> 1));
                    default: be[gi] = 1'b1;
                endcase
            end
        end
    endgenerate

    logic [31:0] regs_reg [NREGS-1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int r = 0; r < NREGS - 1; r++) begin
                regs_reg[r] <= '0;
            end
        end else if (commit) begin
            for (int r = 0; r < NREGS - 1; r++) begin
                if (idx_reg == REGS_EXP'(r)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            regs_reg[r][8*b +: 8] <= HWDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Full register view including the hard-wired ID word.
    logic [31:0] word_all [NREGS];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_words
            if (gi == NREGS - 1) begin : g_id
                assign word_all[gi] = ID_VALUE;
            end else begin : g_rw
                assign word_all[gi] = regs_reg[gi];
            end
            assign REGS_FLAT[32*gi +: 32] = word_all[gi];
        end
    endgenerate

    assign HRDATA = (valid_reg && !err_reg) ? word_all[idx_reg] : 32'h0;

endmodule

// File: tb/tb_ahb_lite_reg_slave.sv
module tb_ahb_lite_reg_slave;

    localparam logic [31:0]  ID       = 32'h5052_4953;
    localparam logic [255:0] RST_FLAT = {ID, 224'h0};

`ifdef AHB_REG_SLAVE_WAIT_EN
    localparam int NW = 2;
`else
    localparam int NW = 0;
`endif

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic         HSEL = 1'b0;
    logic [31:0]  HADDR = '0;
    logic [1:0]   HTRANS = 2'b00;
    logic         HWRITE = 1'b0;
    logic [2:0]   HSIZE = 3'b010;
    logic [31:0]  HWDATA = '0;
    logic         HREADY;
    logic         HREADYOUT;
    logic         HRESP;
    logic [31:0]  HRDATA;
    logic [255:0] REGS_FLAT;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_lite_reg_slave #(
        .REGS_EXP   (3),
        .WAIT_CYCLES(2),
        .ID_VALUE   (ID)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .HRDATA   (HRDATA),
        .REGS_FLAT(REGS_FLAT)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        string       name;
        bit          is_read;
        bit          err;
        int          waits;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];

    // Monitor: follows data phases on the bus and scores each completion.
    bit dp_pending = 0;
    int low_cnt = 0;
    bit resp_low = 0;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dp_pending = 0;
        end else begin
            if (dp_pending) begin
                if (!HREADYOUT) begin
                    low_cnt++;
                    resp_low = resp_low | HRESP;
                end else begin
                    dp_pending = 0;
                    if (sbq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_response: got response with empty queue, required none");
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        $display("txn %s resp=%0d low=%0d rdata=%h", e.name, HRESP, low_cnt, HRDATA);
                        check({e.name, "_resp"}, 256'(HRESP), 256'(e.err));
                        check({e.name, "_lowcycles"}, 256'(low_cnt), 256'(e.err ? 1 : e.waits));
                        check({e.name, "_lowresp"}, 256'(resp_low), 256'(e.err));
                        if (e.is_read || e.err)
                            check({e.name, "_rdata"}, 256'(HRDATA), 256'(e.err ? 32'h0 : e.rdata));
                    end
                end
            end
            if (HSEL && HTRANS[1] && HREADY) begin
                dp_pending = 1;
                low_cnt    = 0;
                resp_low   = 0;
            end
        end
    end

    // Drive one address phase and return just after it is accepted.
    task automatic step(input string nm, input bit push, input logic sel, input logic [1:0] trans,
                        input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, input bit err, input logic [31:0] rdata);
        bit rdy;
        HSEL = sel; HTRANS = trans; HADDR = addr; HWRITE = wr; HSIZE = size;
        if (push && sel && trans[1])
            sbq.push_back('{name: nm, is_read: !wr, err: err, waits: NW, rdata: rdata});
        rdy = 0;
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge HCLK);
            rdy = HREADYOUT;
            @(posedge HCLK);
        end
        if (!rdy) begin
            checks++;
            $display("FAIL %s_accept: HREADYOUT stuck low, required high within 50 cycles", nm);
        end
        #1;
        HWDATA = wdata; HTRANS = 2'b00; HSEL = 1'b0;
    endtask

    task automatic wr(input string nm, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] d, input bit err);
        step(nm, 1, 1'b1, 2'b10, a, 1'b1, s, d, err, 32'h0);
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] exp, input bit err);
        step(nm, 1, 1'b1, 2'b10, a, 1'b0, s, 32'h0, err, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 0, 1'b0, 2'b00, 32'h0, 1'b0, 3'b010, 32'h0, 0, 32'h0);
    endtask

    task automatic reset_check(input string nm);
        HRESETn = 1'b0;
        #1;
        check({nm, "_hreadyout"}, 256'(HREADYOUT), 256'(1'b1));
        check({nm, "_hresp"}, 256'(HRESP), 256'(1'b0));
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle(2);
        check({nm, "_regs"}, REGS_FLAT, RST_FLAT);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("rst_hreadyout", 256'(HREADYOUT), 256'(1'b1));
        check("rst_hresp", 256'(HRESP), 256'(1'b0));
        check("rst_hrdata", 256'(HRDATA), 256'(32'h0));
        check("rst_regs", REGS_FLAT, RST_FLAT);
        @(posedge HCLK);
        #1;

        // Word write/read.
        wr("wr_reg2", 32'h08, 3'b010, 32'hDEADBEEF, 0);
        rd("rd_reg2", 32'h08, 3'b010, 32'hDEADBEEF, 0);
        idle(2);
        check("flat_reg2", 256'(REGS_FLAT[95:64]), 256'(32'hDEADBEEF));

        // Sub-word writes land in the addressed lanes only.
        wr("wr_reg1", 32'h04, 3'b010, 32'h11223344, 0);
        wr("wr_byte5", 32'h05, 3'b000, 32'h0000AA00, 0);
        rd("rd_reg1_b", 32'h04, 3'b010, 32'h1122AA44, 0);
        wr("wr_half6", 32'h06, 3'b001, 32'hBEEF0000, 0);
        rd("rd_reg1_h", 32'h04, 3'b010, 32'hBEEFAA44, 0);
        rd("rd_byte7", 32'h07, 3'b000, 32'hBEEFAA44, 0);

        // Error responses.
        rd("rd_misalign", 32'h02, 3'b010, 32'h0, 1);
        wr("wr_id", 32'h1C, 3'b010, 32'h1, 1);
        rd("rd_id", 32'h1C, 3'b010, ID, 0);
        wr("wr_half_mis", 32'h09, 3'b001, 32'hFFFFFFFF, 1);
        rd("rd_size3", 32'h00, 3'b011, 32'h0, 1);
        rd("rd_reg2_kept", 32'h08, 3'b010, 32'hDEADBEEF, 0);

        // Back-to-back write/read, then BUSY with no effect.
        wr("wr_reg3", 32'h0C, 3'b010, 32'h12345678, 0);
        rd("rd_reg3", 32'h0C, 3'b010, 32'h12345678, 0);
        step("busy", 0, 1'b1, 2'b01, 32'h0C, 1'b1, 3'b010, 32'hFFFFFFFF, 0, 32'h0);
        rd("rd_reg3_busy", 32'h0C, 3'b010, 32'h12345678, 0);
        idle(2);
        check("flat_reg3", 256'(REGS_FLAT[127:96]), 256'(32'h12345678));

        // reg0 write; with waits, the register must stay old until completion.
        wr("wr_reg0", 32'h00, 3'b010, 32'hCAFEF00D, 0);
`ifdef AHB_REG_SLAVE_WAIT_EN
        @(negedge HCLK);
        check("wait1_hreadyout", 256'(HREADYOUT), 256'(1'b0));
        check("wait1_reg0", 256'(REGS_FLAT[31:0]), 256'(32'h0));
        @(negedge HCLK);
        check("wait2_hreadyout", 256'(HREADYOUT), 256'(1'b0));
        @(negedge HCLK);
        check("wait_done_hreadyout", 256'(HREADYOUT), 256'(1'b1));
        check("wait_done_reg0_old", 256'(REGS_FLAT[31:0]), 256'(32'h0));
`endif
        idle(2);
        check("flat_reg0", 256'(REGS_FLAT[31:0]), 256'(32'hCAFEF00D));

        // Reset during ERR1.
        step("rd_err_rst", 0, 1'b1, 2'b10, 32'h03, 1'b0, 3'b010, 32'h0, 1, 32'h0);
        check("err1_state", 256'({HREADYOUT, HRESP}), 256'(2'b01));
        reset_check("rst_err1");

`ifdef AHB_REG_SLAVE_WAIT_EN
        // Reset during WAIT discards the pending write.
        step("wr_wait_rst", 0, 1'b1, 2'b10, 32'h14, 1'b1, 3'b010, 32'h55AA55AA, 0, 32'h0);
        check("wait_state", 256'({HREADYOUT, HRESP}), 256'(2'b00));
        reset_check("rst_wait");
`endif

        idle(2);
        check("scoreboard_drained", 256'(sbq.size()), 256'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_reg_slave.md
Name: ahb_lite_reg_slave

Overview:
- AHB-Lite slave (responder) holding a small bank of 32-bit registers. It drives the HREADYOUT/HRESP/HRDATA signals that the slave-side response mux selects per device.
- Supports byte, halfword and word accesses; configurable wait states; two-cycle ERROR response.
- Sits on one HSEL line of the system bus and exports its register contents to fabric logic.

Parameters:
- REGS_EXP, 3, log2 of register count (8 words, word index = HADDR[REGS_EXP+1:2])
- WAIT_CYCLES, 0, wait states inserted per data phase (0..15); only used when the optional feature is compiled in
- ID_VALUE, 32'h5052_4953, read-only value of the highest-indexed register

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  reset
- HSEL  in  1  slave select from address decoder
- HADDR  in  32  address-phase address
- HTRANS  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
- HWRITE  in  1  1=write
- HSIZE  in  3  000=byte, 001=half, 010=word
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus-level ready (from response mux)
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  32  read data
- REGS_FLAT  out  2**REGS_EXP*32  register contents; reg i at bits [32*i+31:32*i]

Interface note: reset HRESETn, asynchronous, active-low; clock HCLK.

Behaviour:
- Reset values:
  - All registers 0, except the ID register, which is hard-wired to ID_VALUE.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM in IDLE; all captured address-phase state cleared.
- Address-phase capture:
  - Capture occurs when HSEL && HREADY && HTRANS[1].
  - Registered on HCLK: word index, HADDR[1:0], HSIZE, HWRITE, valid=1.
- Pipeline qualification:
  - If HREADY=1 and the capture condition is false, valid is cleared.
  - BUSY and IDLE transfers get a zero-wait OKAY response with no side effect.
- Error classification (decided at capture, recorded as a flag):
  - HSIZE > 010.
  - Misalignment: half with HADDR[0]=1, or word with HADDR[1:0]!=00.
  - Write to the ID register.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Valid capture with error flag → ERR1.
    - Otherwise, valid capture with WAIT_CYCLES>0 → WAIT, wait counter loaded with WAIT_CYCLES-1.
    - Otherwise stays in IDLE and the access completes this data phase.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 0 the state returns to IDLE, so the next cycle is the completing data-phase cycle with HREADYOUT=1.
  - ERR1: HREADYOUT=0, HRESP=1. Always → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. → IDLE; a new capture in the same cycle is processed normally.
- Latency:
  - 0 wait: the data phase ends one cycle after the address phase.
  - N waits: the data phase lasts N+1 cycles.
  - Error: the data phase is always 2 cycles.
- Write commit:
  - Occurs on the completing data-phase edge (HREADYOUT=1 in IDLE state, valid, no error).
  - Byte enables come from HSIZE/HADDR[1:0]: byte → lane HADDR[1:0]; half → lanes {HADDR[1],0} and {HADDR[1],1}; word → all 4 lanes.
  - HWDATA lanes are taken from the matching bit positions; non-enabled bytes are unchanged.
- Read data:
  - HRDATA is the full 32-bit word at the captured index, driven combinationally during the data phase while valid and no error. Byte lanes are not shifted; the master extracts the lane.
  - HRDATA=0 otherwise, including during error responses.
- Erroring writes never modify any register.
- Back-to-back transfers:
  - The next address phase is accepted only when HREADY=1.
  - Write data phase followed by a read address phase to the same register: the read data phase returns the newly written value (write commits before the read data phase).
- Reset mid-transfer (in WAIT or ERR1): immediately HREADYOUT=1, HRESP=0, FSM→IDLE, pending write discarded.

Optional Feature:
- Macro AHB_REG_SLAVE_WAIT_EN.
- Defined: WAIT state and counter are built; WAIT_CYCLES is honoured.
- Undefined: WAIT state, counter and WAIT_CYCLES logic are removed. Every non-error access is zero-wait; error responses remain 2-cycle.

Test Plan:
- Word write reg2=0xDEADBEEF then word read reg2 → OKAY, zero-wait, HRDATA=0xDEADBEEF, REGS_FLAT[95:64]=0xDEADBEEF.
- Byte write 0xAA at HADDR=0x05 over reg1=0x11223344 → reg1=0x1122AA44; half write 0xBEEF at HADDR=0x06 → reg1=0xBEEFAA44.
- Word read at HADDR=0x02 (misaligned) → HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, HRDATA=0. Word write 0x1 to ID register (HADDR=0x1C) → same two-cycle ERROR, ID read still 0x50524953.
- With AHB_REG_SLAVE_WAIT_EN and WAIT_CYCLES=2: word write reg0 → HREADYOUT low for exactly 2 cycles, then high; reg0 updated only on the completing edge.
- Back-to-back write reg3=0x12345678 / read reg3 with HTRANS NONSEQ both cycles → read returns 0x12345678. BUSY (HTRANS=01) cycle inserted → no register change, OKAY.
- Assert HRESETn low during ERR1 or WAIT → next sampled HREADYOUT=1, HRESP=0, all regs 0 except ID.
